// File: rtl/clk_reset_seq.sv
// Reset and clock-enable sequencer for the clk_2x domain: synchronises PLL lock,
// holds sys_reset for a fixed time, then emits divided ce strobes and a 1x phase.
module clk_reset_seq #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HOLD  = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_2x,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_value,
  output logic              sys_reset,
  output logic              ready,
  output logic              phase_1x,
  output logic [NUM_CH-1:0] ce
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_HOLD, ST_RUN} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic                   r_phase;
  logic                   w_lock_s;
  logic                   w_run;
  logic                   w_stay_run;

  assign w_lock_s   = r_sync[SYNC_STAGES-1];
  assign w_run      = (r_state == ST_RUN);
  assign w_stay_run = w_run && w_lock_s;

  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;
  assign phase_1x  = r_phase;

  always_ff @(posedge clk_2x) begin
    if (reset) begin
      r_sync      <= '0;
      r_state     <= ST_WAIT_LOCK;
      r_hold      <= '0;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_phase     <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      case (r_state)
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= ST_HOLD;
            r_hold  <= HOLD_INIT;
          end
        end
        ST_HOLD: begin
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_hold == '0) begin
            r_state     <= ST_RUN;
            r_sys_reset <= 1'b0;
            r_ready     <= 1'b1;
            r_phase     <= 1'b0;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            r_state     <= ST_WAIT_LOCK;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_phase     <= 1'b0;
          end else begin
            r_phase <= ~r_phase;
          end
        end
        default: begin
          r_state     <= ST_WAIT_LOCK;
          r_sys_reset <= 1'b1;
          r_ready     <= 1'b0;
          r_phase     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] w_last;
    logic             w_hit;
    logic             w_ce;

    // Divisors 0 and 1 both collapse to a terminal count of 0.
    assign w_last  = (r_active > DIV_W'(1)) ? (r_active - DIV_W'(1)) : '0;
    assign w_hit   = div_load && (int'(div_ch) == gi);
    assign w_ce    = w_run && (r_cnt == w_last);
    assign ce[gi]  = w_ce;

    always_ff @(posedge clk_2x) begin
      if (reset) begin
        r_cnt    <= '0;
        r_active <= DIV_RST;
        r_shadow <= DIV_RST;
      end else begin
        if (w_hit) begin
          r_shadow <= div_value;
        end
        if (!w_run) begin
          r_cnt <= '0;
          if (w_hit) begin
            r_active <= div_value;
          end
        end else if (w_ce) begin
          // New divisor only takes effect on a wrap so no period is cut short.
          r_cnt    <= '0;
          r_active <= w_hit ? div_value : r_shadow;
        end else begin
          r_cnt <= w_stay_run ? (r_cnt + DIV_W'(1)) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq: table-driven reset sequencing plus hand-written
// divisor-change, bypass, lock-loss and mid-run-reset sequences.
module tb_clk_reset_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset      = 1'b1;
  logic       pll_locked = 1'b0;
  logic       div_load   = 1'b0;
  logic [0:0] div_ch     = 1'b0;
  logic [7:0] div_value  = 8'd0;
  logic       sys_reset, ready, phase_1x;
  logic [1:0] ce;

  logic       div_load3  = 1'b0;
  logic [1:0] div_ch3    = 2'd3;
  logic [7:0] div_value3 = 8'd0;
  logic       sys_reset3, ready3, phase3;
  logic [2:0] ce3;

  clk_reset_seq u_dut (
    .clk_2x    (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .div_load  (div_load),
    .div_ch    (div_ch),
    .div_value (div_value),
    .sys_reset (sys_reset),
    .ready     (ready),
    .phase_1x  (phase_1x),
    .ce        (ce)
  );

  clk_reset_seq #(.NUM_CH(3)) u_dut3 (
    .clk_2x    (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .div_load  (div_load3),
    .div_ch    (div_ch3),
    .div_value (div_value3),
    .sys_reset (sys_reset3),
    .ready     (ready3),
    .phase_1x  (phase3),
    .ce        (ce3)
  );

  typedef struct {
    logic       sr;
    logic       rdy;
    logic       ph;
    logic [1:0] ce;
    logic [2:0] ce3;
    bit         chk3;
    string      nm;
  } exp_t;

  typedef struct {
    logic rst;
    logic lock;
    logic ld;
    logic ld3;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic sr, input logic rdy, input logic ph,
                              input logic [1:0] c, input string nm);
    exp_t e;
    e.sr = sr; e.rdy = rdy; e.ph = ph; e.ce = c;
    e.ce3 = 3'b000; e.chk3 = 1'b0; e.nm = nm;
    return e;
  endfunction

  // Drive one cycle of inputs, expectation describes outputs after the next edge.
  task automatic tick(input logic rst, input logic lock, input logic ld, input logic ch,
                      input logic [7:0] val, input logic ld3, input exp_t e);
    exp_t g;
    logic bad;
    reset = rst; pll_locked = lock; div_load = ld; div_ch = ch; div_value = val;
    div_load3 = ld3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    n_vec++;
    bad = ({sys_reset, ready, phase_1x, ce} !== {g.sr, g.rdy, g.ph, g.ce});
    if (g.chk3 && ({sys_reset3, ready3, phase3, ce3} !== {g.sr, g.rdy, g.ph, g.ce3}))
      bad = 1'b1;
    if (bad) begin
      n_err++;
      $display("FAIL %s #%0d: got sr=%b rdy=%b ph=%b ce=%b ce3=%b, want sr=%b rdy=%b ph=%b ce=%b ce3=%b(chk=%0d)",
               g.nm, n_vec, sys_reset, ready, phase_1x, ce, ce3,
               g.sr, g.rdy, g.ph, g.ce, g.ce3, g.chk3);
    end else begin
      $display("vec %0d %s: sr=%b rdy=%b ph=%b ce=%b ok", n_vec, g.nm,
               sys_reset, ready, phase_1x, ce);
    end
  endtask

  task automatic run_tick(input int n, input logic ld, input logic ch, input logic [7:0] val,
                          input logic [1:0] c, input string nm);
    tick(1'b0, 1'b1, ld, ch, val, 1'b0, mk(1'b0, 1'b1, logic'(n % 2), c, nm));
  endtask

  // Reset (from any state), optionally load both divisors while idle, and walk
  // through the 16-cycle hold; the caller's first run_tick lands on RUN cycle 0.
  task automatic run_up(input bit ld_en, input logic [7:0] v0, input logic [7:0] v1,
                        input string nm);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 2'b00, {nm, "_rst"}));
    for (int k = 1; k <= 18; k++) begin
      logic ld;
      logic ch;
      ld = ld_en && (k == 1 || k == 2);
      ch = (k == 2);
      tick(1'b0, 1'b1, ld, ch, (k == 2) ? v1 : v0, 1'b0,
           mk(1'b1, 1'b0, 1'b0, 2'b00, {nm, "_hold"}));
    end
  endtask

  vec_t tbl[29];

  initial begin
    // Reset sequencing: reset for 3 edges with lock high, RUN on edge 21.
    for (int k = 0; k < 29; k++) begin
      int n;
      n = k - 21;
      tbl[k].rst  = (k < 3);
      tbl[k].lock = 1'b1;
      tbl[k].ld   = (k == 1);
      tbl[k].ld3  = (k == 3);
      if (k < 3)
        tbl[k].e = mk(1'b1, 1'b0, 1'b0, 2'b00, "seq_reset");
      else if (k < 21)
        tbl[k].e = mk(1'b1, 1'b0, 1'b0, 2'b00, "seq_hold");
      else
        tbl[k].e = mk(1'b0, 1'b1, logic'(n % 2), (n % 2 == 1) ? 2'b11 : 2'b00, "seq_run");
      tbl[k].e.chk3 = 1'b1;
      tbl[k].e.ce3  = (k >= 21 && n % 2 == 1) ? 3'b111 : 3'b000;
    end
    for (int k = 0; k < 29; k++)
      tick(tbl[k].rst, tbl[k].lock, tbl[k].ld, 1'b0, 8'd0, tbl[k].ld3, tbl[k].e);

    // Lock glitch mid-hold restarts the full hold; ch0 divisor 0 loaded while idle.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 2'b00, "gl_rst"));
    for (int k = 1; k <= 28; k++) begin
      int n;
      n = k - 25;
      if (k < 25)
        tick(1'b0, (k != 6), (k == 1), 1'b0, 8'd0, 1'b0,
             mk(1'b1, 1'b0, 1'b0, 2'b00, "gl_hold"));
      else
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0,
             mk(1'b0, 1'b1, logic'(n % 2), {logic'(n % 2), 1'b1}, "gl_run"));
    end

    // Glitch-free change on ch0 (4 -> 3 at cycle 5), bypass load on ch1 wrap at cycle 15.
    run_up(1'b1, 8'd4, 8'd2, "gf");
    for (int n = 0; n <= 26; n++) begin
      logic c0, c1;
      c0 = (n == 3 || n == 7 || n == 10 || n == 13 || n == 16 || n == 19 || n == 22 || n == 25);
      c1 = (n <= 15 && n % 2 == 1) || n == 20 || n == 25;
      run_tick(n, (n == 6 || n == 16), (n == 16), (n == 16) ? 8'd5 : 8'd3, {c1, c0}, "gf_run");
    end

    // Lock loss in RUN: two more RUN cycles, then back to reset with ce cleared.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b0, 1'b1, 1'b1, 2'b00, "loss_c27"));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b0, 1'b1, 1'b0, 2'b01, "loss_c28"));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 2'b00, "loss_wait"));
    for (int k = 1; k <= 18; k++)
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 2'b00, "relock_hold"));
    // Divisors kept across lock loss: ch0 D=3, ch1 D=5.
    for (int n = 0; n <= 10; n++)
      run_tick(n, 1'b0, 1'b0, 8'd0, {logic'(n % 5 == 4), logic'(n % 3 == 2)}, "relock_run");

    // Reset asserted in RUN: reset values next cycle, divisors back to default.
    run_up(1'b0, 8'd0, 8'd0, "midrst");
    for (int n = 0; n <= 5; n++)
      run_tick(n, 1'b0, 1'b0, 8'd0, (n % 2 == 1) ? 2'b11 : 2'b00, "midrst_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
